// File: rtl/ifetch_pkg.sv
// Core-wide fetch widths, default slot-buffer depth and the PC step helper.
// ADDR_W/INSTR_W carry the same values as the core's config.vh.
package ifetch_pkg;

   localparam int ADDR_W                   = 32;
   localparam int INSTR_W                  = 32;
   localparam int IFETCH_BUF_DEPTH_DEFAULT = 2;

   // Same instruction-size constant decode adds when forming link values.
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_W);

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } slot_t;

   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/ifetch_slot_buf.sv
// Circular PC/instruction slot buffer: in-order allocate, in-order fill, in-order pop.
module ifetch_slot_buf
   import ifetch_pkg::*;
#(
   parameter int DEPTH = IFETCH_BUF_DEPTH_DEFAULT
) (
   input  logic                         clk,
   input  logic                         aresetn,
   input  logic                         clear,
   input  logic                         alloc,
   input  logic [ADDR_W-1:0]            alloc_pc,
   input  logic                         fill,
   input  logic [INSTR_W-1:0]           fill_data,
   input  logic                         pop,
   output logic                         head_valid,
   output logic [ADDR_W-1:0]            head_pc,
   output logic [INSTR_W-1:0]           head_instr,
   output logic [$clog2(DEPTH+1)-1:0]   alloc_cnt,
   output logic [$clog2(DEPTH+1)-1:0]   unfilled_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0]   head_reg, tail_reg, fill_ptr_reg;
   logic [CNT_W-1:0]   alloc_cnt_reg, fill_cnt_reg;
   logic [DEPTH-1:0]   filled;
   logic [ADDR_W-1:0]  pc_arr    [DEPTH];
   logic [INSTR_W-1:0] instr_arr [DEPTH];
   logic               head_filled, pop_filled, pop_unfilled;

   assign head_filled  = filled[head_reg];
   assign pop_filled   = pop & head_filled;
   // An unfilled head can only be popped when its response bypassed the buffer.
   assign pop_unfilled = pop & ~head_filled;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      slot_t slot_reg;
      logic  filled_reg;

      always_ff @(posedge clk or negedge aresetn) begin
         if (!aresetn) begin
            slot_reg   <= '0;
            filled_reg <= 1'b0;
         end else if (clear) begin
            filled_reg <= 1'b0;
         end else begin
            if (alloc && tail_reg == PTR_W'(gi)) begin
               slot_reg.pc <= alloc_pc;
               filled_reg  <= 1'b0;
            end
            if (pop && head_reg == PTR_W'(gi))
               filled_reg <= 1'b0;
            if (fill && fill_ptr_reg == PTR_W'(gi)) begin
               slot_reg.instr <= fill_data;
               filled_reg     <= 1'b1;
            end
         end
      end

      assign pc_arr[gi]    = slot_reg.pc;
      assign instr_arr[gi] = slot_reg.instr;
      assign filled[gi]    = filled_reg;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         head_reg      <= '0;
         tail_reg      <= '0;
         fill_ptr_reg  <= '0;
         alloc_cnt_reg <= '0;
         fill_cnt_reg  <= '0;
      end else if (clear) begin
         head_reg      <= '0;
         tail_reg      <= '0;
         fill_ptr_reg  <= '0;
         alloc_cnt_reg <= '0;
         fill_cnt_reg  <= '0;
      end else begin
         if (alloc)
            tail_reg <= tail_reg + PTR_W'(1);
         if (pop)
            head_reg <= head_reg + PTR_W'(1);
         if (fill || pop_unfilled)
            fill_ptr_reg <= fill_ptr_reg + PTR_W'(1);
         alloc_cnt_reg <= alloc_cnt_reg + CNT_W'(alloc) - CNT_W'(pop);
         fill_cnt_reg  <= fill_cnt_reg + CNT_W'(fill) - CNT_W'(pop_filled);
      end
   end

   assign head_valid   = (alloc_cnt_reg != '0) & head_filled;
   assign head_pc      = pc_arr[head_reg];
   assign head_instr   = instr_arr[head_reg];
   assign alloc_cnt    = alloc_cnt_reg;
   assign unfilled_cnt = alloc_cnt_reg - fill_cnt_reg;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC, imem request channel, squash/redirect and discard tracking.
// Define IFETCH_BYPASS_EN to present a head-targeted response to decode in the same cycle.
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                BUF_DEPTH = IFETCH_BUF_DEPTH_DEFAULT
) (
   input  logic               clk,
   input  logic               aresetn,
   input  logic               stall,
   input  logic               i_redirect_en,
   input  logic [ADDR_W-1:0]  i_redirect_pc,
   output logic               o_imem_req_valid,
   input  logic               i_imem_req_ready,
   output logic [ADDR_W-1:0]  o_imem_req_addr,
   input  logic               i_imem_rsp_valid,
   input  logic [INSTR_W-1:0] i_imem_rsp_data,
   output logic               o_valid,
   output logic [ADDR_W-1:0]  o_pc,
   output logic [INSTR_W-1:0] o_instr
);

   localparam int CNT_W  = $clog2(BUF_DEPTH+1);
   localparam int DISC_W = $clog2(2*BUF_DEPTH+1);

   logic [ADDR_W-1:0]  fetch_pc_reg;
   logic [DISC_W-1:0]  discard_cnt_reg;
   logic [CNT_W-1:0]   alloc_cnt, unfilled_cnt;
   logic               head_valid;
   logic [ADDR_W-1:0]  head_pc;
   logic [INSTR_W-1:0] head_instr;
   logic               req_fire, rsp_drop, rsp_live, bypass_hit, pop, fill;

   // Request line is held low while reset is asserted.
   assign o_imem_req_valid = aresetn & (alloc_cnt < CNT_W'(BUF_DEPTH)) & ~i_redirect_en;
   assign o_imem_req_addr  = fetch_pc_reg;
   assign req_fire         = o_imem_req_valid & i_imem_req_ready;

   assign rsp_drop = i_imem_rsp_valid & (discard_cnt_reg != '0);
   assign rsp_live = i_imem_rsp_valid & (discard_cnt_reg == '0) & (unfilled_cnt != '0);

`ifdef IFETCH_BYPASS_EN
   assign bypass_hit = rsp_live & (alloc_cnt != '0) & ~head_valid;
`else
   assign bypass_hit = 1'b0;
`endif

   assign o_valid = head_valid | bypass_hit;
   assign o_pc    = o_valid ? head_pc : '0;
   assign o_instr = bypass_hit ? i_imem_rsp_data : (head_valid ? head_instr : '0);

   assign pop  = o_valid & ~stall & ~i_redirect_en;
   assign fill = rsp_live & ~i_redirect_en & ~(bypass_hit & pop);

   ifetch_slot_buf #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk          (clk),
      .aresetn      (aresetn),
      .clear        (i_redirect_en),
      .alloc        (req_fire),
      .alloc_pc     (fetch_pc_reg),
      .fill         (fill),
      .fill_data    (i_imem_rsp_data),
      .pop          (pop),
      .head_valid   (head_valid),
      .head_pc      (head_pc),
      .head_instr   (head_instr),
      .alloc_cnt    (alloc_cnt),
      .unfilled_cnt (unfilled_cnt)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         fetch_pc_reg    <= RESET_PC;
         discard_cnt_reg <= '0;
      end else if (i_redirect_en) begin
         fetch_pc_reg    <= i_redirect_pc;
         // Every squashed in-flight request still owes a response; one landing now is already spent.
         discard_cnt_reg <= discard_cnt_reg - DISC_W'(rsp_drop)
                            + DISC_W'(unfilled_cnt) - DISC_W'(rsp_live);
      end else begin
         if (req_fire)
            fetch_pc_reg <= next_pc(fetch_pc_reg);
         discard_cnt_reg <= discard_cnt_reg - DISC_W'(rsp_drop);
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Table-driven cycle checks of ifetch against a queued in-order instruction memory.
module tb_ifetch;
   import ifetch_pkg::*;

   logic               clk = 1'b0;
   logic               aresetn = 1'b0;
   logic               stall = 1'b0;
   logic               i_redirect_en = 1'b0;
   logic [ADDR_W-1:0]  i_redirect_pc = '0;
   logic               o_imem_req_valid;
   logic               i_imem_req_ready = 1'b1;
   logic [ADDR_W-1:0]  o_imem_req_addr;
   logic               i_imem_rsp_valid = 1'b0;
   logic [INSTR_W-1:0] i_imem_rsp_data = '0;
   logic               o_valid;
   logic [ADDR_W-1:0]  o_pc;
   logic [INSTR_W-1:0] o_instr;

   always #5 clk = ~clk;

   ifetch #(.RESET_PC(32'h100), .BUF_DEPTH(4)) dut (
      .clk              (clk),
      .aresetn          (aresetn),
      .stall            (stall),
      .i_redirect_en    (i_redirect_en),
      .i_redirect_pc    (i_redirect_pc),
      .o_imem_req_valid (o_imem_req_valid),
      .i_imem_req_ready (i_imem_req_ready),
      .o_imem_req_addr  (o_imem_req_addr),
      .i_imem_rsp_valid (i_imem_rsp_valid),
      .i_imem_rsp_data  (i_imem_rsp_data),
      .o_valid          (o_valid),
      .o_pc             (o_pc),
      .o_instr          (o_instr)
   );

   typedef struct {
      logic        stall, ready, rsp_en, redir;
      logic [31:0] rpc;
      logic        ov;
      logic [31:0] pc, instr;
      logic        rv;
      logic [31:0] addr;
   } row_t;

   row_t        vec[$];
   logic [31:0] pend[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_instr[$];
   logic [31:0] exp_pc[$];
   logic [31:0] ovr_addr = 32'h860;
   int          nerr = 0;
   int          nchk = 0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == ovr_addr) ? 32'h0050_0093 : (32'h1300_0000 | a);
   endfunction

   function automatic row_t r(input logic st, input logic rd, input logic re, input logic rdr,
                              input logic [31:0] rpc, input logic ov, input logic [31:0] pc,
                              input logic rv, input logic [31:0] addr);
      row_t x;
      x.stall = st; x.ready = rd; x.rsp_en = re; x.redir = rdr; x.rpc = rpc;
      x.ov = ov; x.pc = ov ? pc : 32'h0; x.instr = ov ? mem_data(pc) : 32'h0;
      x.rv = rv; x.addr = addr;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Sample fire/consume before the edge, then advance to just past it.
   task automatic tick();
      if (o_imem_req_valid && i_imem_req_ready)
         pend.push_back(o_imem_req_addr);
      if (o_valid && !stall && !i_redirect_en) begin
         got_pc.push_back(o_pc);
         got_instr.push_back(o_instr);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_row(input row_t v, input int idx);
      logic [31:0] a;
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = '0;
      if (v.rsp_en && pend.size() > 0) begin
         a = pend.pop_front();
         i_imem_rsp_valid = 1'b1;
         i_imem_rsp_data  = mem_data(a);
      end
      stall            = v.stall;
      i_imem_req_ready = v.ready;
      i_redirect_en    = v.redir;
      i_redirect_pc    = v.rpc;
      #1;
      $display("cyc %0d: rsp=%b/%h valid=%b pc=%h instr=%h req=%b addr=%h",
               idx, i_imem_rsp_valid, i_imem_rsp_data, o_valid, o_pc, o_instr,
               o_imem_req_valid, o_imem_req_addr);
      chk($sformatf("c%0d o_valid", idx), 32'(o_valid), 32'(v.ov));
      chk($sformatf("c%0d o_pc", idx), o_pc, v.pc);
      chk($sformatf("c%0d o_instr", idx), o_instr, v.instr);
      chk($sformatf("c%0d req_valid", idx), 32'(o_imem_req_valid), 32'(v.rv));
      chk($sformatf("c%0d req_addr", idx), o_imem_req_addr, v.addr);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef IFETCH_BYPASS_EN
      ovr_addr = 32'h100;
      vec.push_back(r(0,1,1,0,0, 0,'h000, 1,'h100));
      vec.push_back(r(0,1,1,0,0, 1,'h100, 1,'h120));  // response presented same cycle
      vec.push_back(r(0,1,1,0,0, 1,'h120, 1,'h140));
      vec.push_back(r(1,1,1,0,0, 1,'h140, 1,'h160));  // stalled bypass is written
      vec.push_back(r(0,1,1,0,0, 1,'h140, 1,'h180));
      vec.push_back(r(0,1,1,0,0, 1,'h160, 1,'h1A0));
      exp_pc = '{32'h100, 32'h120, 32'h140, 32'h160};
`else
      vec.push_back(r(0,1,1,0,0,     0,'h000, 1,'h100));  // c0
      vec.push_back(r(0,1,1,0,0,     0,'h000, 1,'h120));  // c1: response, no bypass
      vec.push_back(r(0,1,1,0,0,     1,'h100, 1,'h140));
      vec.push_back(r(0,1,1,0,0,     1,'h120, 1,'h160));
      vec.push_back(r(0,1,1,0,0,     1,'h140, 1,'h180));
      vec.push_back(r(1,1,1,0,0,     1,'h160, 1,'h1A0));  // c5: stall 3 cycles
      vec.push_back(r(1,1,1,0,0,     1,'h160, 1,'h1C0));
      vec.push_back(r(1,1,1,0,0,     1,'h160, 0,'h1E0));  // buffer full
      vec.push_back(r(0,1,1,0,0,     1,'h160, 0,'h1E0));
      vec.push_back(r(0,1,1,0,0,     1,'h180, 1,'h1E0));
      vec.push_back(r(0,1,1,0,0,     1,'h1A0, 1,'h200));  // c10
      vec.push_back(r(0,1,1,0,0,     1,'h1C0, 1,'h220));
      vec.push_back(r(0,1,1,0,0,     1,'h1E0, 1,'h240));
      vec.push_back(r(0,1,1,0,0,     1,'h200, 1,'h260));
      vec.push_back(r(0,1,1,0,0,     1,'h220, 1,'h280));
      vec.push_back(r(0,1,0,0,0,     1,'h240, 1,'h2A0));  // c15: memory holds responses
      vec.push_back(r(0,1,0,1,'h400, 1,'h260, 0,'h2C0));  // redirect, 2 in flight
      vec.push_back(r(0,1,1,0,0,     0,'h000, 1,'h400));  // dropped response
      vec.push_back(r(0,1,1,0,0,     0,'h000, 1,'h420));  // dropped response
      vec.push_back(r(0,1,1,0,0,     0,'h000, 1,'h440));
      vec.push_back(r(0,1,1,0,0,     1,'h400, 1,'h460));  // c20
      vec.push_back(r(0,1,1,1,'h800, 1,'h420, 0,'h480));  // redirect + live response + would-be pop
      vec.push_back(r(0,1,1,0,0,     0,'h000, 1,'h800));
      vec.push_back(r(0,1,1,0,0,     0,'h000, 1,'h820));
      vec.push_back(r(0,1,1,0,0,     1,'h800, 1,'h840));
      vec.push_back(r(0,0,1,0,0,     1,'h820, 1,'h860));  // c25: ready low 5 cycles
      vec.push_back(r(0,0,1,0,0,     1,'h840, 1,'h860));
      vec.push_back(r(0,0,1,0,0,     0,'h000, 1,'h860));
      vec.push_back(r(0,0,1,0,0,     0,'h000, 1,'h860));
      vec.push_back(r(0,0,1,0,0,     0,'h000, 1,'h860));
      vec.push_back(r(0,1,1,0,0,     0,'h000, 1,'h860));  // c30
      vec.push_back(r(0,1,1,0,0,     0,'h000, 1,'h880));
      vec.push_back(r(0,1,1,0,0,     1,'h860, 1,'h8A0));
      exp_pc = '{32'h100, 32'h120, 32'h140, 32'h160, 32'h180, 32'h1A0, 32'h1C0, 32'h1E0,
                 32'h200, 32'h220, 32'h240, 32'h400, 32'h800, 32'h820, 32'h840, 32'h860};
`endif

      // Reset state while held in reset.
      repeat (2) @(posedge clk);
      #1;
      chk("reset o_valid", 32'(o_valid), 32'h0);
      chk("reset o_pc", o_pc, 32'h0);
      chk("reset o_instr", o_instr, 32'h0);
      chk("reset req_valid", 32'(o_imem_req_valid), 32'h0);
      aresetn = 1'b1;

      for (int i = 0; i < vec.size(); i++)
         run_row(vec[i], i);

      chk("consumed count", 32'(got_pc.size()), 32'(exp_pc.size()));
      for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) begin
         chk($sformatf("consumed[%0d] pc", i), got_pc[i], exp_pc[i]);
         chk($sformatf("consumed[%0d] instr", i), got_instr[i], mem_data(exp_pc[i]));
      end

      // Reset asserted mid-operation drops everything immediately.
      aresetn          = 1'b0;
      i_imem_rsp_valid = 1'b0;
      i_redirect_en    = 1'b0;
      stall            = 1'b0;
      i_imem_req_ready = 1'b1;
      pend.delete();
      #1;
      chk("midreset o_valid", 32'(o_valid), 32'h0);
      chk("midreset o_pc", o_pc, 32'h0);
      chk("midreset o_instr", o_instr, 32'h0);
      chk("midreset req_valid", 32'(o_imem_req_valid), 32'h0);
      @(posedge clk);
      #1;
      aresetn = 1'b1;
      #1;
      chk("rerun req_valid", 32'(o_imem_req_valid), 32'h1);
      chk("rerun req_addr", o_imem_req_addr, 32'h100);
      chk("rerun o_valid", 32'(o_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage feeding the decode stage. It issues in-order read requests to instruction memory over a valid/ready request channel and receives in-order responses. A small slot buffer holds fetched PC/instruction pairs and presents them to decode, which consumes one per cycle when not stalled. It also supports squashing and redirecting on branch/jump.

## Interface
- `RESET_PC`, default 0: first fetch address after reset.
- `BUF_DEPTH`, default 2: number of slots in the buffer; a power of two, ≥2.
- `clk` in 1: clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `stall` in 1: decode not accepting this cycle (decode memory hazard).
- `i_redirect_en` in 1: squash all fetched/in-flight instructions and restart at `i_redirect_pc`.
- `i_redirect_pc` in `ADDR_W`: redirect target.
- `o_imem_req_valid` out 1: request valid.
- `i_imem_req_ready` in 1: memory accepts request.
- `o_imem_req_addr` out `ADDR_W`: request address.
- `i_imem_rsp_valid` in 1: response valid; responses are in request order and always accepted.
- `i_imem_rsp_data` in `INSTR_W`: fetched instruction.
- `o_valid` out 1: `o_pc`/`o_instr` hold a real instruction.
- `o_pc` out `ADDR_W`: PC to decode; 0 when `o_valid`=0.
- `o_instr` out `INSTR_W`: instruction to decode; 0 (bubble) when `o_valid`=0.

## Operation
- State: `r_fetch_pc`, circular slot buffer (per slot: pc, instr, filled), head/tail pointers, `alloc_cnt` (0..BUF_DEPTH), `discard_cnt` (in-flight squashed responses).
- Request: `o_imem_req_valid` = `alloc_cnt`<BUF_DEPTH and not `i_redirect_en`; `o_imem_req_addr`=`r_fetch_pc`.
- On request fire, allocate tail slot (pc=`r_fetch_pc`, filled=0) and set `r_fetch_pc` += `INSTR_W`. The PC step equals the instruction-size constant decode adds for link values.
- Response: if `discard_cnt`≠0, drop it and decrement. Otherwise write data into the oldest allocated unfilled slot and set filled.
- Output: head slot allocated and filled → `o_valid`=1, drive its pc/instr; otherwise drive 0/0.
- Pop: `o_valid` and not `stall` → free head, `alloc_cnt`−1. A stall holds the head unchanged.
- Redirect: clear all slots, `alloc_cnt`=0, `r_fetch_pc`=`i_redirect_pc`, no request this cycle. `discard_cnt` += number of allocated unfilled slots, minus 1 if a non-discarded response arrives the same cycle.
- Redirect has priority over pop, fill and request in the same cycle. The squashed head is not consumed; `o_valid` still reflects the pre-redirect head combinationally, and the owner of `i_redirect_en` clears decode.
- Simultaneous pop and request when full: a request needs `alloc_cnt`<BUF_DEPTH at cycle start, so a freed slot is reusable next cycle.
- `discard_cnt` width is clog2(2·BUF_DEPTH+1). Requests may issue while discards are pending.

## Timing
- Reset (async assert): `alloc_cnt`=0, `discard_cnt`=0, `r_fetch_pc`=`RESET_PC`, all slots empty. Outputs: `o_valid`=0, `o_pc`=0, `o_instr`=0, `o_imem_req_valid`=0.
- First cycle after deassert: `o_imem_req_valid`=1 with addr `RESET_PC`.
- Latency: response in cycle N → `o_valid`=1 in cycle N+1 (no bypass).
- Throughput: one instruction per cycle sustained with single-cycle memory and BUF_DEPTH≥2.
- Reset mid-operation drops all state immediately. Responses still in flight at reset are the memory's responsibility and are not counted.

## Configuration
- `IFETCH_BYPASS_EN` defined: when the head slot is the response target, the response presents combinationally in cycle N (`o_valid`=1). If not stalled, it pops without being written to the buffer.
- Not defined: all outputs come from registered slots; latency per Timing.

## Structure
- `ADDR_W`, `INSTR_W` come from `config.vh`.
- Add `IFETCH_BUF_DEPTH_DEFAULT` to `config.vh`.
- Sub-module `ifetch_slot_buf` holds the slot storage, pointers, fill tracking and `alloc_cnt`. `ifetch` keeps the PC, request logic, discard counter and bypass.

## Test plan
- Reset with `RESET_PC`=0x100, memory ready, 1-cycle responses → requests 0x100, 0x120, 0x140…; decode sees the same sequence with `o_valid` continuous after the first response.
- `stall` high 3 cycles with buffer full → head PC held, `o_imem_req_valid`=0; release → in-order drain, no loss or duplication.
- Redirect to 0x400 with 2 requests in flight → next 2 responses dropped; the first `o_valid` carries pc 0x400.
- Redirect in the same cycle as a response and a pop → that response is discarded, `discard_cnt` correct, no head pop.
- `i_imem_req_ready` low 5 cycles → `o_imem_req_addr` stable, `o_valid` falls to 0 with `o_instr`=0 once drained.
- `IFETCH_BYPASS_EN` on, empty buffer, response data 0x00500093 → `o_valid`=1 with that data in the same cycle.
